// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_PORTS cores.
// Each grant runs IDLE -> ACCESS -> RESPOND, and RESPOND returns a one-cycle ack.

`ifndef DATAMEM_ADDR_WIDTH
`define DATAMEM_ADDR_WIDTH 10
`endif
`ifndef DATA_WORD_LENGTH
`define DATA_WORD_LENGTH 32
`endif

module dmem_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = `DATAMEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = `DATA_WORD_LENGTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             req_wr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             ack,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             busy,
  output logic [ADDR_WIDTH-1:0]            DataAddress,
  output logic [DATA_WIDTH-1:0]            DataToWrite,
  output logic                             DataMemWrEn,
  input  logic [DATA_WIDTH-1:0]            DataToRead
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic [IdxW-1:0]       win_q, win_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];
  logic [IdxW-1:0]       pick, cand;
  logic                  found;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Search upward from the port after the last grant, wrapping modulo NUM_PORTS.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = IdxW'((32'(last_q) + k) % NUM_PORTS);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = pick;
          wr_d    = req_wr[pick];
          addr_d  = addr_arr[pick];
          wdata_d = wdata_arr[pick];
          state_d = StAccess;
        end
      end
      StAccess: begin
        rdata_d = DataToRead;
        state_d = StRespond;
      end
      StRespond: begin
        last_d  = win_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= IdxW'(NUM_PORTS - 1);
      win_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == StRespond) ack[win_q] = 1'b1;
  end

  assign rdata       = rdata_q;
  assign busy        = (state_q != StIdle);
  assign DataAddress = addr_q;
  assign DataToWrite = wdata_q;
  // Reset gates the enable directly so a store aborted mid-ACCESS never reaches memory.
  assign DataMemWrEn = (state_q == StAccess) & wr_q & ~reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a slot-level round-robin model
// and a falling-edge memory fixture.

module tb_dmem_arbiter;

  localparam int NP = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NP-1:0]    req = '0;
  logic [NP-1:0]    req_wr = '0;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP*DW-1:0] req_wdata = '0;
  logic [NP-1:0]    ack;
  logic [DW-1:0]    rdata;
  logic             busy;
  logic [AW-1:0]    DataAddress;
  logic [DW-1:0]    DataToWrite;
  logic             DataMemWrEn;
  logic [DW-1:0]    DataToRead;

  dmem_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .ack        (ack),
    .rdata      (rdata),
    .busy       (busy),
    .DataAddress(DataAddress),
    .DataToWrite(DataToWrite),
    .DataMemWrEn(DataMemWrEn),
    .DataToRead (DataToRead)
  );

  always #5 clk = ~clk;

  // Memory fixture clocked on the inverted clock.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] mem_rd = '0;
  assign DataToRead = mem_rd;
  initial for (int i = 0; i < 16; i++) mem[i] = 8'(i * 37 + 11);
  always @(negedge clk) begin
    if (DataMemWrEn) mem[DataAddress] <= DataToWrite;
    mem_rd <= mem[DataAddress];
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: pending requests per port, expected memory contents, slot timeline.
  logic          pend [NP];
  logic          cont [NP];
  logic          pwr  [NP];
  logic [AW-1:0] paddr[NP];
  logic [DW-1:0] pwd  [NP];
  logic [DW-1:0] ref_mem [16];
  int            slot, free_slot, acc_slot, ack_slot, exp_port, last_g;
  logic          exp_wr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  bit            rand_new = 1'b0;
  int            order_q[$];
  int            ack_slots[$];

  function automatic bit any_pend();
    bit a = 1'b0;
    for (int p = 0; p < NP; p++) a |= pend[p];
    return a;
  endfunction

  task automatic new_req(input int p, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    pend[p] = 1'b1;
    pwr[p] = wr;
    paddr[p] = a;
    pwd[p] = d;
  endtask

  // The winner's fields are scrambled while its access is in flight.
  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      req[p] = pend[p];
      if (slot == acc_slot && p == exp_port) begin
        req_wr[p] = ~pwr[p];
        req_addr[p*AW +: AW] = paddr[p] ^ 4'hC;
        req_wdata[p*DW +: DW] = ~pwd[p];
      end else if (pend[p]) begin
        req_wr[p] = pwr[p];
        req_addr[p*AW +: AW] = paddr[p];
        req_wdata[p*DW +: DW] = pwd[p];
      end else begin
        req_wr[p] = 1'($urandom);
        req_addr[p*AW +: AW] = 4'($urandom);
        req_wdata[p*DW +: DW] = 8'($urandom);
      end
    end
  endtask

  task automatic step();
    logic [NP-1:0] exp_ack;
    int done;
    bit got;
    @(posedge clk);
    #2;
    slot++;
    done = -1;
    exp_ack = (slot == ack_slot) ? 4'(1 << exp_port) : 4'b0;
    check_eq("ack", 32'(ack), 32'(exp_ack));
    check_eq("busy", 32'(busy), 32'(slot == acc_slot || slot == ack_slot));
    if (slot == acc_slot) begin
      check_eq("wren", 32'(DataMemWrEn), 32'(exp_wr));
      check_eq("addr", 32'(DataAddress), 32'(exp_addr));
      if (exp_wr) check_eq("wdata", 32'(DataToWrite), 32'(exp_wdata));
    end else begin
      check_eq("wren_idle", 32'(DataMemWrEn), 32'(0));
    end
    if (slot == ack_slot) begin
      if (!exp_wr) check_eq("rdata", 32'(rdata), 32'(ref_mem[exp_addr]));
      else ref_mem[exp_addr] = exp_wdata;
      pend[exp_port] = 1'b0;
      done = exp_port;
      order_q.push_back(exp_port);
      ack_slots.push_back(slot);
    end
    for (int p = 0; p < NP; p++) begin
      if (!pend[p] && p != done && (cont[p] || (rand_new && $urandom_range(0, 3) == 0)))
        new_req(p, 1'($urandom), 4'($urandom), 8'($urandom));
    end
    if (slot >= free_slot) begin
      got = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        int c;
        c = (last_g + k) % NP;
        if (!got && pend[c]) begin
          got = 1'b1;
          exp_port = c;
          exp_wr = pwr[c];
          exp_addr = paddr[c];
          exp_wdata = pwd[c];
          acc_slot = slot + 1;
          ack_slot = slot + 2;
          free_slot = slot + 3;
          last_g = c;
        end
      end
    end
    drive();
    if (slot == acc_slot) begin
      #1;
      check_eq("addr_hold", 32'(DataAddress), 32'(exp_addr));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int p = 0; p < NP; p++) begin
      pend[p] = 1'b0;
      cont[p] = 1'b0;
    end
    drive();
    @(posedge clk);
    #2;
    slot++;
    check_eq("rst_ack", 32'(ack), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_rdata", 32'(rdata), 32'(0));
    check_eq("rst_addr", 32'(DataAddress), 32'(0));
    check_eq("rst_wdata", 32'(DataToWrite), 32'(0));
    check_eq("rst_wren", 32'(DataMemWrEn), 32'(0));
    reset = 1'b0;
    last_g = NP - 1;
    acc_slot = -1;
    ack_slot = -1;
    free_slot = slot;
    order_q.delete();
    ack_slots.delete();
  endtask

  task automatic drain();
    int n = 0;
    while ((any_pend() || slot < free_slot) && n < 200) begin
      step();
      n++;
    end
    check_eq("drain_bound", 32'(n < 200), 32'(1));
  endtask

  initial begin
    int s0, n;
    logic [DW-1:0] wd;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 37 + 11);
    slot = 0;
    exp_port = 0;
    acc_slot = -1;
    do_reset();

    // Port 0 stores 0xA5 to addr 3, then port 2 loads it back.
    new_req(0, 1'b1, 4'd3, 8'hA5);
    s0 = slot + 1;
    drain();
    check_eq("st_latency", 32'(ack_slots[0]), 32'(s0 + 2));
    new_req(2, 1'b0, 4'd3, 8'h00);
    drain();
    check_eq("ld_port", 32'(order_q[order_q.size()-1]), 32'(2));
    check_eq("ld_a5", 32'(ref_mem[3]), 32'(8'hA5));

    // All four ports from reset: order 0..3, three cycles apart.
    do_reset();
    for (int p = 0; p < NP; p++) new_req(p, 1'b0, 4'(p + 8), 8'h00);
    drain();
    check_eq("all4_n", 32'(order_q.size()), 32'(4));
    for (int i = 0; i < 4 && i < order_q.size(); i++) begin
      check_eq("all4_order", 32'(order_q[i]), 32'(i));
      if (i > 0) check_eq("all4_gap", 32'(ack_slots[i] - ack_slots[i-1]), 32'(3));
    end

    // Ports 1 and 3 continuous after a grant to port 1: 3,1,3,1.
    do_reset();
    new_req(1, 1'b0, 4'd1, 8'h00);
    drain();
    order_q.delete();
    cont[1] = 1'b1;
    cont[3] = 1'b1;
    n = 0;
    while (order_q.size() < 4 && n < 60) begin
      step();
      n++;
    end
    cont[1] = 1'b0;
    cont[3] = 1'b0;
    drain();
    check_eq("rr13_n", 32'(order_q.size() >= 4), 32'(1));
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      check_eq("rr13_order", 32'(order_q[i]), 32'((i % 2 == 0) ? 3 : 1));

    // Winner address changes 5->9 during ACCESS.
    new_req(1, 1'b0, 4'd5, 8'h00);
    drain();

    // Reset during ACCESS of a store: no write, no ack.
    do_reset();
    wd = ~ref_mem[7];
    new_req(0, 1'b1, 4'd7, wd);
    n = 0;
    while (slot != acc_slot && n < 10) begin
      step();
      n++;
    end
    check_eq("reach_access", 32'(slot == acc_slot), 32'(1));
    reset = 1'b1;
    #1;
    check_eq("wren_rst", 32'(DataMemWrEn), 32'(0));
    do_reset();
    new_req(1, 1'b0, 4'd7, 8'h00);
    drain();

    // Quiet period.
    repeat (10) step();

    // Random traffic.
    rand_new = 1'b1;
    repeat (400) step();
    rand_new = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter sharing the single-port data memory between `NUM_PORTS` SM cores in the multi-core system. Each core issues one load or store at a time over a req/ack handshake. The arbiter grants one request, performs the memory access, and returns the read data with a one-cycle ack pulse. It sits between the SMCore data ports and the DataMemory instance, which is clocked on inverted `clk`.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesting cores (2..8).
- `ADDR_WIDTH`, `` `DATAMEM_ADDR_WIDTH ``: data memory address width.
- `DATA_WIDTH`, `` `DATA_WORD_LENGTH ``: data word width.

Ports (per-port buses are flattened; port i occupies `[i*W +: W]`):
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_PORTS  request from port i; held high until its ack.
- `req_wr`  in  NUM_PORTS  1 = store, 0 = load.
- `req_addr`  in  NUM_PORTS*ADDR_WIDTH  access address per port.
- `req_wdata`  in  NUM_PORTS*DATA_WIDTH  store data per port.
- `ack`  out  NUM_PORTS  one-cycle completion pulse; at most one bit set.
- `rdata`  out  DATA_WIDTH  load data; valid while any `ack` bit is high.
- `busy`  out  1  high in ACCESS and RESPOND.
- `DataAddress`  out  ADDR_WIDTH  to DataMemory address.
- `DataToWrite`  out  DATA_WIDTH  to DataMemory write data.
- `DataMemWrEn`  out  1  to DataMemory write enable.
- `DataToRead`  in  DATA_WIDTH  from DataMemory read data.

## Operation
- FSM with three states: IDLE → ACCESS → RESPOND → IDLE.
- IDLE with no `req` bit set: stay in IDLE.
- IDLE with any `req` bit set:
  - Select the winner: the first set bit searching upward from `last_grant+1`, wrapping modulo NUM_PORTS.
  - Latch the winner's index, `req_wr`, `req_addr` and `req_wdata` into internal registers.
  - Go to ACCESS.
- ACCESS:
  - `DataAddress` and `DataToWrite` come from the latched registers.
  - `DataMemWrEn` = latched wr.
  - The memory samples at the falling edge inside ACCESS.
  - At the closing rising edge, capture `DataToRead` into the `rdata` register (also captured for stores; value don't-care).
  - Go to RESPOND.
- RESPOND:
  - `ack[winner]` = 1 and `rdata` is valid.
  - `last_grant` ← winner.
  - Go to IDLE.
- `req` is sampled only in IDLE. A requester drops `req` in the cycle after it sees `ack`, so it is not re-granted.
- `req_wr`/`req_addr`/`req_wdata` changes after latching have no effect on the access in flight.
- Round-robin fairness: with all ports requesting continuously, grants rotate 0,1,2,…,NUM_PORTS-1,0. No port waits more than NUM_PORTS transactions.
- Outside ACCESS, `DataMemWrEn` = 0. `DataAddress`/`DataToWrite` hold their latched values (no toggling).

## Timing
- Latency: `req` rising in IDLE cycle T gives ACCESS at T+1, `ack` at T+2, IDLE at T+3.
- Throughput: one access per 3 cycles. Back-to-back requests from other ports are granted in the IDLE cycle at T+3.
- `ack`, `rdata`, `busy` and the memory-side outputs are registered or pure state decodes.
- Reset values:
  - State IDLE; `last_grant` = NUM_PORTS-1, so port 0 wins first.
  - `ack` = 0, `rdata` = 0, `busy` = 0.
  - `DataAddress` = 0, `DataToWrite` = 0, `DataMemWrEn` = 0.
- Reset mid-operation: `DataMemWrEn` is gated with `~reset`, so no store occurs in any cycle where `reset` is high.
  - An in-flight transaction is dropped with no `ack`.
  - The requester must keep `req` high to be re-served after reset.
- A single requester gets its first `ack` 2 cycles after `req` is seen.
- Simultaneous requests with no history: the lowest index wins.

## Test plan
- Reset, then port 0 stores 0xA5 to addr 3 → `DataMemWrEn`=1 for exactly one cycle with `DataAddress`=3; `ack[0]` 2 cycles after `req`; then a port 2 load of addr 3 returns `rdata`=0xA5 with `ack[2]`.
- All 4 ports request loads together from reset → acks in order 0,1,2,3, each 3 cycles apart; only one `ack` bit ever set.
- Ports 1 and 3 request continuously, `last_grant`=1 → grant order 3,1,3,1.
- `req_addr` of the winner changes during ACCESS (5→9) → `DataAddress` stays 5 and the memory access uses 5.
- `reset` asserted during ACCESS of a store → `DataMemWrEn` stays 0, the memory word is unchanged, no `ack`; all outputs read reset values next cycle.
- No requests for 10 cycles → state IDLE, `busy`=0, `DataMemWrEn`=0 throughout.
